sonar_scheduler: RTL
====================

SONAR_SCHEDULER -- requirements
Module: sonar_scheduler

Interface
REQ-001 Parameter NUM_CH, default 4: number of ultrasonic sensors sharing one ultra_sonic measurement core.
REQ-002 Parameter TIMEOUT_CYC, default 3_000_000: maximum clk cycles to wait for core_count_ready (60 ms at 50 MHz).
REQ-003 Parameter GAP_CYC, default 500_000: quiet cycles between consecutive pings, for echo decay.
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 reset_all  in  1  asynchronous, active-high reset.
REQ-006 enable  in  1  run sweeps continuously while high.
REQ-007 ch_mask  in  NUM_CH  per-channel enable; bit i=1 includes sensor i.
REQ-008 sensor_echo  in  NUM_CH  raw echo lines from sensors.
REQ-009 sensor_pulse  out  NUM_CH  trigger lines to sensors.
REQ-010 core_start  out  1  one-cycle start strobe to the core.
REQ-011 core_pulse  in  1  trigger output from the core.
REQ-012 core_echo  out  1  muxed echo to the core.
REQ-013 core_count_ready  in  1  core result strobe.
REQ-014 core_count  in  23  core echo-width count.
REQ-015 rd_ch  in  CH_W  result read select; CH_W = max(1, $clog2(NUM_CH)).
REQ-016 rd_data  out  23  stored result for rd_ch, combinational.
REQ-017 rd_fresh  out  1  result for rd_ch not yet acknowledged.
REQ-018 rd_ack  in  1  clears fresh flag of rd_ch.
REQ-019 busy  out  1  high in any state other than IDLE.
REQ-020 sweep_done  out  1  one-cycle pulse after last masked channel of a sweep is stored.

Function
REQ-021 FSM states: IDLE, SELECT, START, WAIT, GAP.
REQ-022 IDLE -> SELECT when enable=1 and ch_mask!=0; ch_mask latched into sweep_mask at this transition and held for the whole sweep.
REQ-023 SELECT: cur_ch = lowest set bit of sweep_mask at or above next_ch, wrapping; -> START next cycle.
REQ-024 START: core_start=1 for exactly one cycle; -> WAIT.
REQ-025 core_echo = sensor_echo[cur_ch]; sensor_pulse[cur_ch] = core_pulse; all other sensor_pulse bits 0; in IDLE core_echo=0.
REQ-026 WAIT: on core_count_ready, result[cur_ch] <= core_count, fresh[cur_ch] <= 1; -> GAP.
REQ-027 WAIT timeout: wait counter reaching TIMEOUT_CYC-1 stores 23'h7FFFFF with fresh=1; -> GAP.
REQ-028 GAP: count GAP_CYC cycles; then SELECT if channels remain in sweep, else pulse sweep_done and go SELECT (new sweep, relatch ch_mask) if enable && ch_mask!=0, else IDLE.
REQ-029 enable falling mid-sweep: current channel completes through GAP, then IDLE; no new core_start issued.
REQ-030 rd_ack with a same-cycle result write to rd_ch: write wins, fresh stays 1.
REQ-031 Single masked channel: repeated pings on that channel, sweep_done every measurement.
REQ-032 Wait and gap counters 23 bits wide, saturate, never wrap.

Reset
REQ-033 reset_all asserted: state=IDLE, next_ch=0, cur_ch=0, all results 0, all fresh 0, core_start=0, sensor_pulse=0, busy=0, sweep_done=0, asynchronously, including mid-measurement.

Configuration
REQ-034 Macro SONAR_TIMEOUT_EN defined: REQ-027 timeout active.
REQ-035 SONAR_TIMEOUT_EN undefined: WAIT exits only on core_count_ready; TIMEOUT_CYC ignored; no timeout counter synthesized.

Structure
REQ-036 Package sonar_pkg holds the state enum, COUNT_W=23, and the timeout sentinel 23'h7FFFFF.
REQ-037 Sub-module sonar_result_bank holds result/fresh storage with write, ack and combinational read ports.

Verification
REQ-038 TIMEOUT_CYC=200, GAP_CYC=10; mask=4'b0101, enable; core returns 100 on ch0, 250 on ch2 -> starts ch0,ch2,ch0; rd_data(0)=100, rd_data(2)=250, sweep_done after ch2.
REQ-039 mask=4'b1000, core silent -> after 200 WAIT cycles result[3]=23'h7FFFFF, fresh=1 (macro on); macro off -> stays in WAIT.
REQ-040 mask changed 4'b0011->4'b0100 during ch0 measurement -> ch1 still measured, ch2 begins next sweep.
REQ-041 enable dropped in WAIT of ch1 -> result stored, GAP completes, IDLE, busy=0, no further core_start.
REQ-042 rd_ack on rd_ch=0 coincident with ch0 result write -> rd_fresh remains 1; lone rd_ack later -> 0.
REQ-043 reset_all pulsed during WAIT -> all outputs at reset values in the same cycle; mask=0 with enable=1 -> remains IDLE.

Source files
------------

// File: rtl/sonar_pkg.sv
// Shared types and constants for the multi-sensor sonar scheduler.
package sonar_pkg;
  localparam int COUNT_W = 23;
  localparam logic [COUNT_W-1:0] TIMEOUT_VAL = 23'h7FFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_START,
    ST_WAIT,
    ST_GAP
  } state_e;
endpackage

// File: rtl/sonar_result_bank.sv
// Per-channel result storage with fresh flags; a write beats a same-cycle ack.
module sonar_result_bank
  import sonar_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en_i,
  input  logic [CH_W-1:0]    wr_ch_i,
  input  logic [COUNT_W-1:0] wr_data_i,
  input  logic               ack_i,
  input  logic [CH_W-1:0]    ack_ch_i,
  input  logic [CH_W-1:0]    rd_ch_i,
  output logic [COUNT_W-1:0] rd_data_o,
  output logic               rd_fresh_o
);
  logic [COUNT_W-1:0] result_q [NUM_CH];
  logic [NUM_CH-1:0]  fresh_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) result_q[i] <= '0;
      fresh_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_en_i && wr_ch_i == CH_W'(i)) begin
          result_q[i] <= wr_data_i;
          fresh_q[i]  <= 1'b1;
        end else if (ack_i && ack_ch_i == CH_W'(i)) begin
          fresh_q[i] <= 1'b0;
        end
      end
    end
  end

  assign rd_data_o  = result_q[rd_ch_i];
  assign rd_fresh_o = fresh_q[rd_ch_i];
endmodule

// File: rtl/sonar_scheduler.sv
// Round-robin scheduler sharing one ultrasonic core across NUM_CH sensors.
// Define SONAR_TIMEOUT_EN to abandon silent measurements after TIMEOUT_CYC cycles.
module sonar_scheduler
  import sonar_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int TIMEOUT_CYC = 3_000_000,
  parameter int GAP_CYC     = 500_000,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               reset_all,
  input  logic               enable,
  input  logic [NUM_CH-1:0]  ch_mask,
  input  logic [NUM_CH-1:0]  sensor_echo,
  output logic [NUM_CH-1:0]  sensor_pulse,
  output logic               core_start,
  input  logic               core_pulse,
  output logic               core_echo,
  input  logic               core_count_ready,
  input  logic [COUNT_W-1:0] core_count,
  input  logic [CH_W-1:0]    rd_ch,
  output logic [COUNT_W-1:0] rd_data,
  output logic               rd_fresh,
  input  logic               rd_ack,
  output logic               busy,
  output logic               sweep_done
);
  localparam logic [COUNT_W-1:0] GAP_LAST = COUNT_W'(GAP_CYC - 1);

  state_e              state_q, state_d;
  logic [CH_W-1:0]     cur_ch_q, cur_ch_d, next_ch_q, next_ch_d, sel_ch;
  logic [NUM_CH-1:0]   sweep_mask_q, sweep_mask_d;
  logic [COUNT_W-1:0]  gap_cnt_q, gap_cnt_d, wr_data;
  logic                wr_en, remaining;

`ifdef SONAR_TIMEOUT_EN
  localparam logic [COUNT_W-1:0] TO_LAST = COUNT_W'(TIMEOUT_CYC - 1);
  logic [COUNT_W-1:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == ST_START) wait_cnt_d = '0;
    else if (state_q == ST_WAIT && wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset_all) begin
    if (reset_all) wait_cnt_q <= '0;
    else           wait_cnt_q <= wait_cnt_d;
  end
`endif

  // Lowest masked channel at or above next_ch, falling back to the lowest overall.
  always_comb begin
    logic found;
    sel_ch = '0;
    found  = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (sweep_mask_q[i] && CH_W'(i) >= next_ch_q) begin
        sel_ch = CH_W'(i);
        found  = 1'b1;
      end
    end
    if (!found) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (sweep_mask_q[i]) sel_ch = CH_W'(i);
      end
    end
  end

  always_comb begin
    remaining = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sweep_mask_q[i] && CH_W'(i) > cur_ch_q) remaining = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    cur_ch_d     = cur_ch_q;
    next_ch_d    = next_ch_q;
    sweep_mask_d = sweep_mask_q;
    gap_cnt_d    = gap_cnt_q;
    wr_en        = 1'b0;
    wr_data      = core_count;
    sweep_done   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable && |ch_mask) begin
          sweep_mask_d = ch_mask;
          next_ch_d    = '0;
          state_d      = ST_SELECT;
        end
      end
      ST_SELECT: begin
        cur_ch_d = sel_ch;
        state_d  = ST_START;
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (core_count_ready) wr_en = 1'b1;
`ifdef SONAR_TIMEOUT_EN
        else if (wait_cnt_q == TO_LAST) begin
          wr_en   = 1'b1;
          wr_data = TIMEOUT_VAL;
        end
`endif
        if (wr_en) begin
          state_d   = ST_GAP;
          gap_cnt_d = '0;
          next_ch_d = (cur_ch_q == CH_W'(NUM_CH - 1)) ? '0 : cur_ch_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q >= GAP_LAST) begin
          sweep_done = !remaining;
          if (!enable) begin
            state_d = ST_IDLE;
          end else if (remaining) begin
            state_d = ST_SELECT;
          end else if (|ch_mask) begin
            sweep_mask_d = ch_mask;
            next_ch_d    = '0;
            state_d      = ST_SELECT;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (gap_cnt_q != '1) begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_all) begin
    if (reset_all) begin
      state_q      <= ST_IDLE;
      cur_ch_q     <= '0;
      next_ch_q    <= '0;
      sweep_mask_q <= '0;
      gap_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      cur_ch_q     <= cur_ch_d;
      next_ch_q    <= next_ch_d;
      sweep_mask_q <= sweep_mask_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

  always_comb begin
    sensor_pulse = '0;
    if (state_q != ST_IDLE) sensor_pulse[cur_ch_q] = core_pulse;
  end

  assign core_echo  = (state_q != ST_IDLE) ? sensor_echo[cur_ch_q] : 1'b0;
  assign core_start = (state_q == ST_START);
  assign busy       = (state_q != ST_IDLE);

  sonar_result_bank #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_bank (
    .clk        (clk),
    .rst        (reset_all),
    .wr_en_i    (wr_en),
    .wr_ch_i    (cur_ch_q),
    .wr_data_i  (wr_data),
    .ack_i      (rd_ack),
    .ack_ch_i   (rd_ch),
    .rd_ch_i    (rd_ch),
    .rd_data_o  (rd_data),
    .rd_fresh_o (rd_fresh)
  );
endmodule
